target_addr_hold_reg: RTL and testbench
=======================================

Name: target_addr_hold_reg

Overview:
- Single-stage, clock-enabled holding register for a branch/jump target address in the MIPS CPU datapath.
- Captures the target computed in one pipeline stage (tgt_addr_0) and presents it one cycle later (tgt_addr_1) to PC-update logic.
- Holds its value while the CPU is stalled (clk_enable low).
- Clears to zero on reset.

Parameters:
- ADDR_W, 32, width of the target address in bits.
- RESET_VAL, 32'h0000_0000, value loaded on reset; must remain 0 for CPU integration.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears the register immediately.
- clk_enable  input  1  CPU-wide advance enable; 1 = capture, 0 = hold.
- tgt_addr_0  input  ADDR_W  target address computed in the current cycle.
- tgt_addr_1  output  ADDR_W  registered target address, one cycle delayed.

Behaviour:
- Storage: one ADDR_W-bit register drives tgt_addr_1 directly. No combinational path from tgt_addr_0 to tgt_addr_1.
- Reset:
  - When reset goes to 0, tgt_addr_1 becomes RESET_VAL (0) immediately, without waiting for a clock edge.
  - It stays 0 for as long as reset is 0, regardless of clk, clk_enable or tgt_addr_0.
- Capture: on a rising clk edge with reset=1 and clk_enable=1, tgt_addr_1 <= tgt_addr_0 sampled at that edge. Latency is exactly 1 cycle.
- Hold: on a rising clk edge with reset=1 and clk_enable=0, tgt_addr_1 is unchanged. Any number of consecutive hold cycles is allowed.
- Reset release: deassertion takes effect for the next rising edge. The first capture happens at the first rising edge where reset=1 and clk_enable=1; until then the output stays 0.
- Reset mid-operation: an asserted reset overrides a simultaneous capture. The value captured before reset is lost.
- Width: full ADDR_W-bit copy, no truncation, sign handling or alignment masking. Every bit pattern passes through, including 32'hFFFF_FFFF and unaligned addresses.
- X-handling: the output must be a known value immediately after the first reset assertion.

Decomposition:
- Shared CPU package holds the address-width constant (ADDR_W = 32) and the reset-address constant; this block's defaults reference them.
- No sub-modules: the block is one flip-flop bank with asynchronous clear and clock enable.
- An optional generic enabled-register primitive (en_reg) may be used if the codebase already provides one; otherwise implement it inline.

Test Plan:
- Reset: drive reset=0 mid-cycle with tgt_addr_0=32'hDEADBEEF, clk_enable=1 -> tgt_addr_1=0 immediately, before the next edge, and still 0 after 3 edges.
- Capture: reset=1, clk_enable=1, tgt_addr_0=32'h0040_0010 at edge N -> tgt_addr_1=32'h0040_0010 1 ns after edge N. Apply 32'hBFC0_0000 at edge N+1 -> output follows.
- Hold: load 32'h1234_5678, then clk_enable=0 for 5 edges while tgt_addr_0 cycles random values -> tgt_addr_1 stays 32'h1234_5678 throughout.
- Priority and release: reset=0 together with clk_enable=1 and tgt_addr_0=32'hFFFF_FFFF -> output 0. Release reset with clk_enable=0 -> still 0. Then clk_enable=1 with 32'hFFFF_FFFF -> output 32'hFFFF_FFFF.
- Randomized: 100 cycles with random tgt_addr_0, random clk_enable, and reset asserted about 1% of cycles. A scoreboard model checks after every edge: reset -> 0; enable -> equals the input sampled at that edge; otherwise the previous value.

Source files
------------

// File: rtl/target_addr_hold_reg_pkg.sv
// Shared CPU datapath constants used by the target-address pipeline register.
// Latency: n/a (constants only).
// Backpressure: n/a.
package target_addr_hold_reg_pkg;

  // Width of an instruction address in the MIPS datapath.
  localparam int unsigned CPU_ADDR_W = 32;

  // Address that pipeline address registers return to on reset. PC-update
  // logic relies on a cleared target register, so this stays zero.
  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_ADDR = 32'h0000_0000;

endpackage : target_addr_hold_reg_pkg

// File: rtl/target_addr_hold_reg.sv
// Holds the branch/jump target computed in one stage for PC-update logic in the next.
// Latency: 1 cycle from tgt_addr_0 to tgt_addr_1; no combinational path through.
// Backpressure: clk_enable low (CPU stall) freezes the stored target indefinitely.
module target_addr_hold_reg
  import target_addr_hold_reg_pkg::*;
#(
  parameter int unsigned          ADDR_W    = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_VAL = CPU_RESET_ADDR[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              reset,       // asynchronous, active-low
  input  logic              clk_enable,  // 1 = capture, 0 = hold
  input  logic [ADDR_W-1:0] tgt_addr_0,
  output logic [ADDR_W-1:0] tgt_addr_1
);

  logic [ADDR_W-1:0] tgt_addr_q;

  // Target register: async clear wins over any capture; otherwise load when the CPU advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_addr_q <= RESET_VAL;
    end else if (clk_enable) begin
      tgt_addr_q <= tgt_addr_0;
    end
  end

  assign tgt_addr_1 = tgt_addr_q;

endmodule : target_addr_hold_reg

// File: tb/tb_target_addr_hold_reg.sv
// Directed and randomized checks of the target-address hold register.
// Latency: expects tgt_addr_1 one edge after capture, immediately on reset.
// Backpressure: exercises hold cycles with clk_enable low.
module tb_target_addr_hold_reg;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         clk_enable;
  logic [W-1:0] tgt_addr_0;
  logic [W-1:0] tgt_addr_1;

  int unsigned  pass_cnt;
  int unsigned  total_cnt;
  logic [W-1:0] model_q;
  logic         rnd_rst;
  logic         rnd_en;
  logic [W-1:0] rnd_addr;

  target_addr_hold_reg #(
    .ADDR_W    (W),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .tgt_addr_0 (tgt_addr_0),
    .tgt_addr_1 (tgt_addr_1)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive inputs on the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic rst_v, input logic en_v, input logic [W-1:0] addr_v);
    @(negedge clk);
    reset      = rst_v;
    clk_enable = en_v;
    tgt_addr_0 = addr_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    reset      = 1'b1;
    clk_enable = 1'b1;
    tgt_addr_0 = 32'hDEAD_BEEF;

    // Reset asserted mid-cycle: output clears before any edge.
    #7;
    reset = 1'b0;
    #1;
    check("reset_immediate", tgt_addr_1, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", tgt_addr_1, 32'h0000_0000);
    end

    // Capture after release, one value per edge.
    step(1'b1, 1'b1, 32'h0040_0010);
    check("capture_first", tgt_addr_1, 32'h0040_0010);
    step(1'b1, 1'b1, 32'hBFC0_0000);
    check("capture_next", tgt_addr_1, 32'hBFC0_0000);
    step(1'b1, 1'b1, 32'h0000_0003);
    check("capture_unaligned", tgt_addr_1, 32'h0000_0003);

    // Hold for five stalled edges while the input keeps changing.
    step(1'b1, 1'b1, 32'h1234_5678);
    check("hold_load", tgt_addr_1, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, $urandom());
      check("hold_stall", tgt_addr_1, 32'h1234_5678);
    end

    // Reset overrides a simultaneous capture, then release under stall.
    @(negedge clk);
    reset      = 1'b0;
    clk_enable = 1'b1;
    tgt_addr_0 = 32'hFFFF_FFFF;
    #1;
    check("prio_immediate", tgt_addr_1, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("prio_edge", tgt_addr_1, 32'h0000_0000);
    step(1'b1, 1'b0, 32'hFFFF_FFFF);
    check("release_stalled", tgt_addr_1, 32'h0000_0000);
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    check("release_capture_ones", tgt_addr_1, 32'hFFFF_FFFF);

    // Randomized run against a reference model; cycle 50 always resets.
    model_q = 32'hFFFF_FFFF;
    for (int i = 0; i < 100; i++) begin
      rnd_rst  = (i == 50 || $urandom_range(99) == 0) ? 1'b0 : 1'b1;
      rnd_en   = 1'($urandom_range(1));
      rnd_addr = $urandom();
      step(rnd_rst, rnd_en, rnd_addr);
      if (!rnd_rst)     model_q = 32'h0000_0000;
      else if (rnd_en)  model_q = rnd_addr;
      check("random", tgt_addr_1, model_q);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_target_addr_hold_reg
